// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: shared types and constants for the divider sequencer.
package div_ctrl_pkg;

    // Operand width of the shared divider (fixed at 32).
    localparam int DATA_W_DEF = 32;

    // Busy-cycle counter width; 7 bits cover the ~67-iteration worst case.
    localparam int CNT_W_DEF = 7;

    // Quotient reported for a zero divisor when the divider is bypassed.
    localparam logic [31:0] DIV0_QUO = 32'hFFFF_FFFF;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage : div_ctrl_pkg

// File: rtl/div_ctrl_if.sv
// div_ctrl_if: operand/result handshake between the sequencer (master)
// and the shared iterative divider (slave).
interface div_ctrl_if
    import div_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic                dv_rst;        // divider sync reset / abort
    logic [DATA_W-1:0]   dv_a;          // latched dividend
    logic [DATA_W-1:0]   dv_b;          // latched divisor
    logic                dv_sign;       // latched signedness
    logic                dv_opn_valid;  // single-cycle launch pulse
    logic                dv_res_valid;  // divider has a result
    logic                dv_res_ready;  // sequencer takes the result
    logic [2*DATA_W-1:0] dv_result;     // {remainder, quotient}

    modport master (
        output dv_rst, dv_a, dv_b, dv_sign, dv_opn_valid, dv_res_ready,
        input  dv_res_valid, dv_result
    );

    modport slave (
        input  dv_rst, dv_a, dv_b, dv_sign, dv_opn_valid, dv_res_ready,
        output dv_res_valid, dv_result
    );

endinterface : div_ctrl_if

// File: rtl/div_busy_cnt.sv
// div_busy_cnt: saturating up-counter measuring how long the divider is busy.
// Clear has priority over enable; the count sticks at all-ones.
module div_busy_cnt #(
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    // Count busy cycles, saturating so a slow divider never wraps to a small value.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block evaluation order.
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule : div_busy_cnt

// File: rtl/div_ctrl.sv
// div_ctrl: EX-stage sequencer for the shared iterative divider.
// Launches the divider once per DIV/DIVU, stalls EX while it runs, holds
// {HI,LO} until EX advances, and aborts the divider on an exception flush.
// Optional build macro: DIV_ZERO_BYPASS_EN -- a zero divisor completes
// locally (LO = all-ones, HI = dividend) without launching the divider.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              div_req,
    input  logic              div_sign,
    input  logic [DATA_W-1:0] div_a,
    input  logic [DATA_W-1:0] div_b,
    input  logic              flush,
    input  logic              ex_stall_in,
    output logic              div_stall,
    output logic              res_valid_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic [CNT_W-1:0]  last_cycles,
    div_ctrl_if.master        dv_if
);

    div_state_e        state_q;
    div_state_e        state_d;

    logic              launch;     // IDLE -> BUSY this cycle
    logic              capture;    // BUSY -> DONE with a divider result
    logic              bypass;     // IDLE -> DONE without the divider
    logic              div0_skip;  // zero divisor resolved locally
    logic              cnt_en;

    logic [DATA_W-1:0] dv_a_q;
    logic [DATA_W-1:0] dv_b_q;
    logic              dv_sign_q;
    logic              opn_valid_q;
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;
    logic [CNT_W-1:0]  last_q;
    logic [CNT_W-1:0]  busy_cnt;

`ifdef DIV_ZERO_BYPASS_EN
    assign div0_skip = (div_b == '0);
`else
    assign div0_skip = 1'b0;
`endif

    // State register; reset returns to IDLE from anywhere, including mid-division.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and single-cycle launch/capture/bypass strobes.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case statement can infer a latch.
        state_d = state_q;
        launch  = 1'b0;
        capture = 1'b0;
        bypass  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (div_req && !flush) begin
                    if (div0_skip) begin
                        bypass  = 1'b1;
                        state_d = DONE;
                    end else begin
                        launch  = 1'b1;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                // A flush wins over a coincident result: the result is dropped.
                if (flush) begin
                    state_d = IDLE;
                end else if (dv_if.dv_res_valid) begin
                    capture = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                // Holding in DONE while EX is stalled never relaunches, even
                // though div_req is still asserted by the same instruction.
                if (flush || !ex_stall_in) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand latch, launch pulse, and result/statistics capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dv_a_q      <= '0;
            dv_b_q      <= '0;
            dv_sign_q   <= 1'b0;
            opn_valid_q <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            last_q      <= '0;
        end else begin
            opn_valid_q <= launch;
            // Operands are sampled only at launch; later forwarding changes
            // while EX is stalled must not reach the divider.
            if (launch) begin
                dv_a_q    <= div_a;
                dv_b_q    <= div_b;
                dv_sign_q <= div_sign;
            end
            if (capture) begin
                hi_q   <= dv_if.dv_result[2*DATA_W-1:DATA_W];
                lo_q   <= dv_if.dv_result[DATA_W-1:0];
                last_q <= busy_cnt;
            end else if (bypass) begin
                hi_q   <= div_a;
                lo_q   <= DATA_W'(DIV0_QUO);
                last_q <= '0;
            end
        end
    end

    assign cnt_en = (state_q == BUSY);

    div_busy_cnt #(
        .CNT_W (CNT_W)
    ) u_busy_cnt (
        .clk (clk),
        .rst (rst),
        .clr (launch),
        .en  (cnt_en),
        .cnt (busy_cnt)
    );

    // Pipeline-facing outputs.
    assign div_stall   = div_req && !flush && ((state_q == IDLE) || (state_q == BUSY));
    assign res_valid_o = (state_q == DONE);
    assign hi_o        = hi_q;
    assign lo_o        = lo_q;
    assign last_cycles = last_q;

    // Divider-facing outputs. The abort is combinational so the divider's
    // synchronous reset sees it on the same edge the controller leaves BUSY.
    assign dv_if.dv_rst       = rst || (flush && (state_q == BUSY));
    assign dv_if.dv_a         = dv_a_q;
    assign dv_if.dv_b         = dv_b_q;
    assign dv_if.dv_sign      = dv_sign_q;
    assign dv_if.dv_opn_valid = opn_valid_q;
    assign dv_if.dv_res_ready = (state_q == BUSY) && dv_if.dv_res_valid && !flush;

    // The instruction owning the divider must stay in EX until it completes or is flushed.
    a_req_held_in_busy: assert property (
        @(posedge clk) disable iff (rst)
        ((state_q == BUSY) && !flush) |-> div_req
    );

endmodule : div_ctrl
